// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller.
// Contents:
//   pctl_state_t : controller FSM state encoding
//   pipe_en_t    : bundle of per-stage write-enable and flush controls
//   PIPE_*       : canned control bundles for the common cases
//   run_rules    : control bundle when the MEM stage is not blocking
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {INIT, RUN, MEMWAIT, ERROR} pctl_state_t;

    typedef struct packed {
        logic pc_wr;
        logic ifid_wr;
        logic idex_wr;
        logic exmem_wr;
        logic memwb_wr;
        logic ifid_fl;
        logic idex_fl;
        logic memwb_fl;
    } pipe_en_t;

    localparam pipe_en_t PIPE_RUN    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    // Everything up to EX/MEM holds; MEM/WB takes a bubble while memory is busy.
    localparam pipe_en_t PIPE_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    localparam pipe_en_t PIPE_INIT   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam pipe_en_t PIPE_HALT   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // A redirect squashes the instruction that would have stalled, so it wins over hazard.
    function automatic pipe_en_t run_rules(input logic redirect, input logic hazard);
        pipe_en_t en;
        en = PIPE_RUN;
        if (redirect) begin
            en.ifid_fl = 1'b1;
            en.idex_fl = 1'b1;
        end else if (!hazard) begin
            en.pc_wr   = 1'b0;
            en.ifid_wr = 1'b0;
            en.idex_fl = 1'b1;
        end
        return en;
    endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter used for performance statistics.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high clear
//   inc   : count one event this cycle
//   count : current value; holds at all-ones
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush controller: consumes load-use hazard, EX redirect and
// data-memory ready, and drives per-stage write enables and flushes. Also
// sequences post-reset warm-up, memory waits and a memory-timeout trap.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   hazard                : 0 = load-use stall request
//   PCSrcEX               : redirect taken in EX
//   MemAccessMEM          : MEM stage holds a load/store
//   dmem_ready            : data memory completes the access this cycle
//   PCWrite..MEMWBWrite   : stage load enables
//   IFIDFlush..MEMWBFlush : stage bubble inserts
//   mem_timeout           : sticky memory-timeout flag
//   stall_cnt, flush_cnt  : saturating perf counters
//
// state   | meaning
// INIT    | warm-up bubbles after reset, PC held
// RUN     | normal operation, hazard/redirect handling
// MEMWAIT | data memory busy, front of pipe frozen
// ERROR   | memory timed out, pipeline halted until reset
module pipeline_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int INIT_CYCLES = 2,
    parameter int TIMEOUT     = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hazard,
    input  logic             PCSrcEX,
    input  logic             MemAccessMEM,
    input  logic             dmem_ready,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IDEXWrite,
    output logic             EXMEMWrite,
    output logic             MEMWBWrite,
    output logic             IFIDFlush,
    output logic             IDEXFlush,
    output logic             MEMWBFlush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [INIT_W-1:0] INIT_LOAD  = INIT_W'(INIT_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT);

    pctl_state_t       state, state_nxt;
    logic [INIT_W-1:0] init_cnt, init_cnt_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic              timeout_q, timeout_nxt;
    pipe_en_t          en;
    logic              stall_inc;
    logic              flush_inc;

    always_ff @(posedge clk) begin
        state     <= state_nxt;
        init_cnt  <= init_cnt_nxt;
        wait_cnt  <= wait_cnt_nxt;
        timeout_q <= timeout_nxt;
    end

    // Reset is folded in here so the outputs show INIT values during reset
    // regardless of the state being left.
    always_comb begin
        en           = PIPE_RUN;
        state_nxt    = state;
        init_cnt_nxt = init_cnt;
        wait_cnt_nxt = wait_cnt;
        timeout_nxt  = timeout_q;
        flush_inc    = 1'b0;
        if (reset) begin
            en           = PIPE_INIT;
            state_nxt    = INIT;
            init_cnt_nxt = INIT_LOAD;
            wait_cnt_nxt = '0;
            timeout_nxt  = 1'b0;
        end else begin
            case (state)
                INIT: begin
                    en = PIPE_INIT;
                    if (init_cnt == '0) state_nxt = RUN;
                    else                init_cnt_nxt = init_cnt - 1'b1;
                end
                RUN: begin
                    if (MemAccessMEM && !dmem_ready) begin
                        en           = PIPE_FREEZE;
                        wait_cnt_nxt = WAIT_W'(1);
                        state_nxt    = MEMWAIT;
                    end else begin
                        en        = run_rules(PCSrcEX, hazard);
                        flush_inc = PCSrcEX;
                    end
                end
                MEMWAIT: begin
                    if (!dmem_ready) begin
                        en = PIPE_FREEZE;
                        if (wait_cnt != '1) wait_cnt_nxt = wait_cnt + 1'b1;
                        if ((TIMEOUT != 0) && (wait_cnt == WAIT_LIMIT)) begin
                            state_nxt   = ERROR;
                            timeout_nxt = 1'b1;
                        end
                    end else begin
                        en        = run_rules(PCSrcEX, hazard);
                        flush_inc = PCSrcEX;
                        state_nxt = RUN;
                    end
                end
                ERROR:   en = PIPE_HALT;
                default: state_nxt = INIT;
            endcase
        end
        stall_inc = !reset && ((state == RUN) || (state == MEMWAIT)) && !en.pc_wr;
    end

    assign PCWrite     = en.pc_wr;
    assign IFIDWrite   = en.ifid_wr;
    assign IDEXWrite   = en.idex_wr;
    assign EXMEMWrite  = en.exmem_wr;
    assign MEMWBWrite  = en.memwb_wr;
    assign IFIDFlush   = en.ifid_fl;
    assign IDEXFlush   = en.idex_fl;
    assign MEMWBFlush  = en.memwb_fl;
    assign mem_timeout = timeout_q;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl (INIT_CYCLES=2, TIMEOUT=4, CNT_W=3).
// Control vector order: PCWrite IFIDWrite IDEXWrite EXMEMWrite MEMWBWrite
//                       IFIDFlush IDEXFlush MEMWBFlush
module tb_pipeline_stall_ctrl;

    localparam logic [7:0] V_INIT   = 8'b0111_1110;
    localparam logic [7:0] V_RUN    = 8'b1111_1000;
    localparam logic [7:0] V_HAZ    = 8'b0011_1010;
    localparam logic [7:0] V_REDIR  = 8'b1111_1110;
    localparam logic [7:0] V_FREEZE = 8'b0000_1001;
    localparam logic [7:0] V_HALT   = 8'b0000_0000;

    logic       clk = 1'b0;
    logic       reset, hazard, PCSrcEX, MemAccessMEM, dmem_ready;
    logic       PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, MEMWBWrite;
    logic       IFIDFlush, IDEXFlush, MEMWBFlush, mem_timeout;
    logic [2:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.INIT_CYCLES(2), .TIMEOUT(4), .CNT_W(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .hazard       (hazard),
        .PCSrcEX      (PCSrcEX),
        .MemAccessMEM (MemAccessMEM),
        .dmem_ready   (dmem_ready),
        .PCWrite      (PCWrite),
        .IFIDWrite    (IFIDWrite),
        .IDEXWrite    (IDEXWrite),
        .EXMEMWrite   (EXMEMWrite),
        .MEMWBWrite   (MEMWBWrite),
        .IFIDFlush    (IFIDFlush),
        .IDEXFlush    (IDEXFlush),
        .MEMWBFlush   (MEMWBFlush),
        .mem_timeout  (mem_timeout),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input string tag, input logic [7:0] exp);
        logic [7:0] obs;
        obs = {PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, MEMWBWrite,
               IFIDFlush, IDEXFlush, MEMWBFlush};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        hazard       = 1'b1;
        PCSrcEX      = 1'b0;
        MemAccessMEM = 1'b0;
        dmem_ready   = 1'b0;
    endtask

    // Reset for one edge, then run through the two INIT cycles into RUN.
    task automatic reset_to_run();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        step();
        step();
    endtask

    initial begin
        // Test 1: reset and warm-up bubbles, with inputs that must be ignored in INIT
        idle_inputs();
        reset = 1'b1;
        #1;
        check_vec("reset_outputs", V_INIT);
        step();
        reset   = 1'b0;
        hazard  = 1'b0;
        PCSrcEX = 1'b1;
        #1;
        check_vec("init_cycle1", V_INIT);
        check_val("reset_stall_cnt", 8'(stall_cnt), 8'd0);
        check_val("reset_mem_timeout", 8'(mem_timeout), 8'd0);
        step();
        check_vec("init_cycle2", V_INIT);
        idle_inputs();
        step();
        #1;
        check_vec("run_after_init", V_RUN);
        check_val("init_flush_cnt", 8'(flush_cnt), 8'd0);
        check_val("init_stall_cnt", 8'(stall_cnt), 8'd0);

        // Test 2: single load-use stall
        hazard = 1'b0;
        #1;
        check_vec("hazard_stall", V_HAZ);
        step();
        hazard = 1'b1;
        #1;
        check_val("hazard_stall_cnt", 8'(stall_cnt), 8'd1);
        check_vec("hazard_release", V_RUN);

        // Test 3: redirect wins over simultaneous hazard
        reset_to_run();
        hazard  = 1'b0;
        PCSrcEX = 1'b1;
        #1;
        check_vec("redirect_over_hazard", V_REDIR);
        step();
        idle_inputs();
        #1;
        check_val("redirect_flush_cnt", 8'(flush_cnt), 8'd1);
        check_val("redirect_stall_cnt", 8'(stall_cnt), 8'd0);

        // Test 4: three-cycle memory wait, then completion
        reset_to_run();
        MemAccessMEM = 1'b1;
        #1;
        check_vec("memwait_c1", V_FREEZE);
        step();
        check_vec("memwait_c2", V_FREEZE);
        step();
        check_vec("memwait_c3", V_FREEZE);
        step();
        dmem_ready = 1'b1;
        #1;
        check_vec("memwait_done", V_RUN);
        step();
        MemAccessMEM = 1'b0;
        dmem_ready   = 1'b0;
        #1;
        check_vec("memwait_back_run", V_RUN);
        check_val("memwait_stall_cnt", 8'(stall_cnt), 8'd3);
        check_val("memwait_no_timeout", 8'(mem_timeout), 8'd0);

        // Memory completes on the same cycle a redirect is pending in EX
        MemAccessMEM = 1'b1;
        PCSrcEX      = 1'b1;
        #1;
        check_vec("memwait_redir_freeze", V_FREEZE);
        step();
        dmem_ready = 1'b1;
        #1;
        check_vec("memwait_redir_done", V_REDIR);
        step();
        idle_inputs();
        #1;
        check_val("memwait_redir_flush_cnt", 8'(flush_cnt), 8'd1);
        check_val("memwait_redir_stall_cnt", 8'(stall_cnt), 8'd4);

        // Test 5: timeout trap after four MEMWAIT cycles
        reset_to_run();
        MemAccessMEM = 1'b1;
        step();
        step();
        step();
        step();
        check_vec("timeout_last_wait", V_FREEZE);
        check_val("timeout_not_yet", 8'(mem_timeout), 8'd0);
        step();
        check_vec("error_halt", V_HALT);
        check_val("error_mem_timeout", 8'(mem_timeout), 8'd1);
        check_val("error_stall_cnt", 8'(stall_cnt), 8'd5);
        dmem_ready = 1'b1;
        step();
        check_vec("error_sticky", V_HALT);
        check_val("error_stall_hold", 8'(stall_cnt), 8'd5);
        reset = 1'b1;
        #1;
        check_vec("error_reset_outputs", V_INIT);
        step();
        reset = 1'b0;
        idle_inputs();
        #1;
        check_val("error_reset_timeout", 8'(mem_timeout), 8'd0);
        check_vec("error_reset_init", V_INIT);

        // Test 6: ten stalls saturate a 3-bit counter
        reset_to_run();
        hazard = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check_vec("sat_still_stalling", V_HAZ);
        check_val("sat_stall_cnt", 8'(stall_cnt), 8'd7);
        hazard = 1'b1;
        step();
        check_val("sat_stall_hold", 8'(stall_cnt), 8'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
